// File: rtl/led_pattern_engine.sv
`timescale 1ns/1ps
// led_pattern_engine: computes a hue for each LED, fetches the matching RGB word
// from an external hue-to-RGB converter and writes it into the LED frame RAM.
// It then hands the frame to the serial driver through a level handshake, waits
// a programmable gap and advances the base hue. Supports solid, rainbow, chase
// and blank patterns.
module led_pattern_engine #(
    parameter int LED_NUM   = 16,
    parameter int ADDR_BIT  = $clog2(LED_NUM),
    parameter int COLOR_W   = 24,
    parameter int COLOR_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [8:0]          hue_step,
    input  logic [8:0]          hue_spread,
    input  logic [31:0]         frame_delay,
    output logic [9:0]          Hue,
    input  logic [COLOR_W-1:0]  COLOR,
    output logic                ram_wrclock,
    output logic [ADDR_BIT-1:0] ram_wraddress,
    output logic [COLOR_W-1:0]  ram_data,
    output logic                update_request,
    input  logic                update_done,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_RAINBOW = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BLANK   = 2'd3
    } mode_e;

    typedef enum logic [3:0] {
        IDLE,
        SETHUE,
        WAIT_COLOR,
        LATCH,
        WR_HI,
        WR_LO,
        REQ,
        WAIT_DONE,
        DELAY
    } state_e;

    // Latency counter holds 0..COLOR_LAT-1; keep at least one bit.
    localparam int LAT_W = (COLOR_LAT > 1) ? $clog2(COLOR_LAT) : 1;

    // Hue inputs above 359 are treated as 359.
    function automatic logic [8:0] clamp_hue(input logic [8:0] v);
        return (v >= 9'd360) ? 9'd359 : v;
    endfunction

    // (a + b) mod 360 for a <= 359, b <= 359: one add, one conditional subtract.
    function automatic logic [9:0] hue_add(input logic [9:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = a + {1'b0, b};
        return (s >= 10'd360) ? (s - 10'd360) : s;
    endfunction

    state_e                r_state;
    state_e                w_next_state;

    mode_e                 r_mode;
    logic [8:0]            r_step;
    logic [8:0]            r_spread;
    logic [31:0]           r_delay;

    logic [9:0]            r_base_hue;
    logic [9:0]            r_led_hue;
    logic [ADDR_BIT-1:0]   r_chase_pos;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [31:0]           r_dly_cnt;

    logic [9:0]            r_hue;
    logic                  r_wrclock;
    logic [ADDR_BIT-1:0]   r_addr;
    logic [COLOR_W-1:0]    r_data;
    logic                  r_req;
    logic                  r_busy;
    logic [15:0]           r_frame_cnt;

    logic                  w_start;
    logic                  w_lat_done;
    logic                  w_last_led;
    logic                  w_dly_done;
    logic                  w_chase_hit;

    assign w_start     = enable && update_done;
    assign w_lat_done  = (r_lat_cnt == LAT_W'(COLOR_LAT - 1));
    assign w_last_led  = (r_addr == ADDR_BIT'(LED_NUM - 1));
    // Delay of 0 or 1 leaves after one DELAY cycle; N > 1 stays N cycles.
    assign w_dly_done  = (({1'b0, r_dly_cnt} + 33'd1) >= {1'b0, r_delay});
    assign w_chase_hit = (r_addr == r_chase_pos);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode for the frame sequencer.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:       if (w_start) w_next_state = SETHUE;
            SETHUE:     w_next_state = WAIT_COLOR;
            WAIT_COLOR: if (w_lat_done) w_next_state = LATCH;
            LATCH:      w_next_state = WR_HI;
            WR_HI:      w_next_state = WR_LO;
            WR_LO:      w_next_state = w_last_led ? REQ : SETHUE;
            REQ:        if (!update_done) w_next_state = WAIT_DONE;
            WAIT_DONE:  if (update_done) w_next_state = DELAY;
            DELAY:      if (w_dly_done) w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Datapath: frame settings, per-LED hue/address/data, handshake and frame bookkeeping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode      <= MODE_SOLID;
            r_step      <= '0;
            r_spread    <= '0;
            r_delay     <= '0;
            r_base_hue  <= '0;
            r_led_hue   <= '0;
            r_chase_pos <= '0;
            r_lat_cnt   <= '0;
            r_dly_cnt   <= '0;
            r_hue       <= '0;
            r_wrclock   <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // Strobe, request and busy are registered decodes of the upcoming state.
            r_wrclock <= (w_next_state == WR_HI);
            r_req     <= (w_next_state == REQ);
            r_busy    <= (w_next_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mode    <= mode_e'(mode);
                        r_step    <= clamp_hue(hue_step);
                        r_spread  <= clamp_hue(hue_spread);
                        r_delay   <= frame_delay;
                        r_led_hue <= r_base_hue;
                        r_addr    <= '0;
                    end
                end
                SETHUE: begin
                    r_hue     <= r_led_hue;
                    r_lat_cnt <= '0;
                end
                WAIT_COLOR: begin
                    r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                end
                LATCH: begin
                    case (r_mode)
                        MODE_SOLID,
                        MODE_RAINBOW: r_data <= COLOR;
                        MODE_CHASE:   r_data <= w_chase_hit ? COLOR : '0;
                        default:      r_data <= '0;
                    endcase
                end
                WR_LO: begin
                    if (!w_last_led) begin
                        r_addr <= r_addr + ADDR_BIT'(1);
                        if (r_mode == MODE_RAINBOW)
                            r_led_hue <= hue_add(r_led_hue, r_spread);
                    end
                end
                WAIT_DONE: begin
                    r_dly_cnt <= '0;
                end
                DELAY: begin
                    if (w_dly_done) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        if (r_mode != MODE_BLANK)
                            r_base_hue <= hue_add(r_base_hue, r_step);
                        if (r_mode == MODE_CHASE)
                            r_chase_pos <= (r_chase_pos == ADDR_BIT'(LED_NUM - 1)) ?
                                           '0 : (r_chase_pos + ADDR_BIT'(1));
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Hue            = r_hue;
    assign ram_wrclock    = r_wrclock;
    assign ram_wraddress  = r_addr;
    assign ram_data       = r_data;
    assign update_request = r_req;
    assign busy           = r_busy;
    assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_led_pattern_engine.sv
`timescale 1ns/1ps
// Testbench for led_pattern_engine: 4 LEDs, converter latency 2, converter
// modelled as a 2-stage pipeline returning {14'b0, Hue}. A table of frames with
// hand-computed RAM contents is run back to back, followed by hand-written
// sequences for enable dropping mid-frame and reset during a RAM write.
module tb_led_pattern_engine;

    localparam int LED_NUM   = 4;
    localparam int ADDR_BIT  = 2;
    localparam int COLOR_W   = 24;
    localparam int COLOR_LAT = 2;
    localparam int LED_CYC   = COLOR_LAT + 4;
    localparam int NV        = 14;

    localparam logic [1:0] M_SOLID   = 2'd0;
    localparam logic [1:0] M_RAINBOW = 2'd1;
    localparam logic [1:0] M_CHASE   = 2'd2;
    localparam logic [1:0] M_BLANK   = 2'd3;

    typedef struct packed {
        logic [1:0]        mode;
        logic [8:0]        step;
        logic [8:0]        spread;
        logic [31:0]       delay;
        logic [7:0]        hold;      // cycles update_done stays 1 after request
        logic [7:0]        low;       // cycles update_done stays 0
        logic [3:0][23:0]  exp_data;  // expected RAM word per address
        logic [15:0]       exp_fc;
        logic [31:0]       exp_dly;   // cycles from WAIT_DONE exit to IDLE
    } vec_t;

    logic                CLK;
    logic                RST_N;
    logic                enable;
    logic [1:0]          mode;
    logic [8:0]          hue_step;
    logic [8:0]          hue_spread;
    logic [31:0]         frame_delay;
    logic [9:0]          Hue;
    logic [COLOR_W-1:0]  COLOR;
    logic                ram_wrclock;
    logic [ADDR_BIT-1:0] ram_wraddress;
    logic [COLOR_W-1:0]  ram_data;
    logic                update_request;
    logic                update_done;
    logic                busy;
    logic [15:0]         frame_cnt;

    led_pattern_engine #(
        .LED_NUM  (LED_NUM),
        .ADDR_BIT (ADDR_BIT),
        .COLOR_W  (COLOR_W),
        .COLOR_LAT(COLOR_LAT)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .enable        (enable),
        .mode          (mode),
        .hue_step      (hue_step),
        .hue_spread    (hue_spread),
        .frame_delay   (frame_delay),
        .Hue           (Hue),
        .COLOR         (COLOR),
        .ram_wrclock   (ram_wrclock),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .update_request(update_request),
        .update_done   (update_done),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hue-to-RGB converter model with COLOR_LAT cycles of latency.
    logic [COLOR_W-1:0] conv_pipe [COLOR_LAT];
    always @(posedge CLK) begin
        conv_pipe[0] <= {14'b0, Hue};
        for (int k = 1; k < COLOR_LAT; k++) conv_pipe[k] <= conv_pipe[k-1];
    end
    assign COLOR = conv_pipe[COLOR_LAT-1];

    // RAM write monitor, sampled on the falling edge.
    int                 cyc = 0;
    int                 wide_err = 0;
    int                 stab_err = 0;
    int                 hue_err = 0;
    logic               prev_wr = 1'b0;
    logic [ADDR_BIT-1:0] last_addr = '0;
    logic [COLOR_W-1:0] last_data = '0;
    int                 wq_addr [$];
    logic [COLOR_W-1:0] wq_data [$];
    int                 wq_cyc  [$];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (ram_wrclock === 1'b1) begin
            if (prev_wr) wide_err <= wide_err + 1;
            wq_addr.push_back(int'(ram_wraddress));
            wq_data.push_back(ram_data);
            wq_cyc.push_back(cyc);
            last_addr <= ram_wraddress;
            last_data <= ram_data;
        end else if (prev_wr && RST_N && (ram_wraddress !== last_addr || ram_data !== last_data)) begin
            stab_err <= stab_err + 1;
        end
        if (Hue > 10'd359) hue_err <= hue_err + 1;
        prev_wr <= ram_wrclock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hue"},     32'(Hue), 32'd0);
        check({tag, "_wrclk"},   32'(ram_wrclock), 32'd0);
        check({tag, "_addr"},    32'(ram_wraddress), 32'd0);
        check({tag, "_data"},    32'(ram_data), 32'd0);
        check({tag, "_req"},     32'(update_request), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_fcnt"},    32'(frame_cnt), 32'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [8:0] st, input logic [8:0] sp,
                                input logic [31:0] dl, input logic [7:0] h, input logic [7:0] l,
                                input logic [23:0] d0, input logic [23:0] d1,
                                input logic [23:0] d2, input logic [23:0] d3,
                                input logic [15:0] fc, input logic [31:0] edly);
        vec_t v;
        v.mode = m;  v.step = st;  v.spread = sp;  v.delay = dl;
        v.hold = h;  v.low = l;
        v.exp_data[0] = d0;  v.exp_data[1] = d1;
        v.exp_data[2] = d2;  v.exp_data[3] = d3;
        v.exp_fc = fc;  v.exp_dly = edly;
        return v;
    endfunction

    // Serve one frame as the driver: wait for the request, run the handshake,
    // load the next frame's inputs while the block sits in WAIT_DONE, then
    // compare the RAM writes and frame bookkeeping against the vector.
    task automatic run_frame(input int idx, input vec_t v, input vec_t nv, input logic next_en);
        int         c;
        int         bad;
        int         nwr;
        logic [15:0] fc0;
        string      p;
        p = $sformatf("f%0d_", idx);

        c = 0;
        while (update_request !== 1'b1 && c < 300) begin tick(); c++; end
        check({p, "req_seen"}, 32'(update_request), 32'd1);
        check({p, "busy_in_req"}, 32'(busy), 32'd1);
        nwr = wq_addr.size();
        check({p, "writes_at_req"}, 32'(nwr), 32'(LED_NUM));
        fc0 = frame_cnt;

        bad = 0;
        for (int k = 0; k < int'(v.hold); k++) begin
            tick();
            if (update_request !== 1'b1) bad++;
        end
        check({p, "req_held"}, 32'(bad), 32'd0);

        update_done = 1'b0;
        tick();
        check({p, "req_fall"}, 32'(update_request), 32'd0);
        mode        = nv.mode;
        hue_step    = nv.step;
        hue_spread  = nv.spread;
        frame_delay = nv.delay;
        enable      = next_en;
        bad = 0;
        for (int k = 1; k < int'(v.low); k++) begin
            tick();
            if (update_request !== 1'b0 || frame_cnt !== fc0 || busy !== 1'b1) bad++;
        end
        check({p, "wait_done_quiet"}, 32'(bad), 32'd0);
        check({p, "no_wr_handshake"}, 32'(wq_addr.size()), 32'(nwr));

        update_done = 1'b1;
        c = 0;
        do begin tick(); c++; end while (frame_cnt === fc0 && c < 400);
        check({p, "delay_cycles"}, 32'(c - 1), v.exp_dly);
        check({p, "frame_cnt"}, 32'(frame_cnt), 32'(v.exp_fc));
        check({p, "writes_total"}, 32'(wq_addr.size()), 32'(LED_NUM));

        for (int a = 0; a < LED_NUM; a++) begin
            if (a < wq_addr.size()) begin
                check($sformatf("%saddr%0d", p, a), 32'(wq_addr[a]), 32'(a));
                check($sformatf("%sdata%0d", p, a), 32'(wq_data[a]), 32'(v.exp_data[a]));
                if (a > 0)
                    check($sformatf("%sspacing%0d", p, a), 32'(wq_cyc[a] - wq_cyc[a-1]), 32'(LED_CYC));
            end
        end
        clear_writes();
    endtask

    // Idle hold: after enable has dropped, nothing moves.
    task automatic check_idle(input string tag);
        int bad;
        check({tag, "_busy_fell"}, 32'(busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy !== 1'b0 || update_request !== 1'b0 || ram_wrclock !== 1'b0) bad++;
        end
        check({tag, "_idle_stays"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs [NV];
    vec_t va;
    vec_t vb;

    initial begin
        // mode, step, spread, delay, hold, low, data[0..3], frame_cnt, delay cycles
        vecs[0]  = mk(M_SOLID,   9'd1,   9'd0,   32'd0,  8'd2, 8'd3,  24'd0,   24'd0,   24'd0,   24'd0,   16'd1,  32'd1);
        vecs[1]  = mk(M_SOLID,   9'd1,   9'd0,   32'd0,  8'd2, 8'd3,  24'd1,   24'd1,   24'd1,   24'd1,   16'd2,  32'd1);
        vecs[2]  = mk(M_SOLID,   9'd298, 9'd0,   32'd0,  8'd2, 8'd3,  24'd2,   24'd2,   24'd2,   24'd2,   16'd3,  32'd1);
        vecs[3]  = mk(M_RAINBOW, 9'd400, 9'd100, 32'd50, 8'd2, 8'd3,  24'd300, 24'd40,  24'd140, 24'd240, 16'd4,  32'd50);
        vecs[4]  = mk(M_RAINBOW, 9'd10,  9'd500, 32'd3,  8'd7, 8'd20, 24'd299, 24'd298, 24'd297, 24'd296, 16'd5,  32'd3);
        vecs[5]  = mk(M_CHASE,   9'd10,  9'd0,   32'd1,  8'd2, 8'd3,  24'd309, 24'd0,   24'd0,   24'd0,   16'd6,  32'd1);
        vecs[6]  = mk(M_CHASE,   9'd10,  9'd0,   32'd0,  8'd2, 8'd3,  24'd0,   24'd319, 24'd0,   24'd0,   16'd7,  32'd1);
        vecs[7]  = mk(M_CHASE,   9'd10,  9'd0,   32'd0,  8'd2, 8'd3,  24'd0,   24'd0,   24'd329, 24'd0,   16'd8,  32'd1);
        vecs[8]  = mk(M_CHASE,   9'd10,  9'd0,   32'd0,  8'd2, 8'd3,  24'd0,   24'd0,   24'd0,   24'd339, 16'd9,  32'd1);
        vecs[9]  = mk(M_CHASE,   9'd20,  9'd0,   32'd0,  8'd2, 8'd3,  24'd349, 24'd0,   24'd0,   24'd0,   16'd10, 32'd1);
        vecs[10] = mk(M_BLANK,   9'd5,   9'd100, 32'd0,  8'd2, 8'd3,  24'd0,   24'd0,   24'd0,   24'd0,   16'd11, 32'd1);
        vecs[11] = mk(M_CHASE,   9'd1,   9'd0,   32'd0,  8'd2, 8'd3,  24'd0,   24'd9,   24'd0,   24'd0,   16'd12, 32'd1);
        vecs[12] = mk(M_RAINBOW, 9'd350, 9'd359, 32'd0,  8'd2, 8'd3,  24'd10,  24'd9,   24'd8,   24'd7,   16'd13, 32'd1);
        vecs[13] = mk(M_SOLID,   9'd7,   9'd0,   32'd2,  8'd2, 8'd3,  24'd0,   24'd0,   24'd0,   24'd0,   16'd14, 32'd2);
        va       = mk(M_SOLID,   9'd0,   9'd0,   32'd2,  8'd2, 8'd3,  24'd7,   24'd7,   24'd7,   24'd7,   16'd15, 32'd2);
        vb       = mk(M_RAINBOW, 9'd5,   9'd100, 32'd0,  8'd2, 8'd3,  24'd0,   24'd100, 24'd200, 24'd300, 16'd1,  32'd1);

        RST_N       = 1'b0;
        enable      = 1'b0;
        mode        = M_SOLID;
        hue_step    = '0;
        hue_spread  = '0;
        frame_delay = '0;
        update_done = 1'b1;
        repeat (3) tick();
        check_reset_vals("por");
        RST_N = 1'b1;
        tick();

        // Back-to-back frames from the table.
        mode        = vecs[0].mode;
        hue_step    = vecs[0].step;
        hue_spread  = vecs[0].spread;
        frame_delay = vecs[0].delay;
        enable      = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i < NV - 1) run_frame(i, vecs[i], vecs[i+1], 1'b1);
            else            run_frame(i, vecs[i], vecs[i], 1'b0);
        end
        check_idle("tbl_end");

        // enable drops during the first RAM write: the frame still completes.
        mode        = va.mode;
        hue_step    = va.step;
        hue_spread  = va.spread;
        frame_delay = va.delay;
        enable      = 1'b1;
        begin
            int c;
            c = 0;
            while (wq_addr.size() == 0 && c < 100) begin tick(); c++; end
            check("ena_first_write_seen", 32'(wq_addr.size()), 32'd1);
        end
        enable = 1'b0;
        run_frame(100, va, va, 1'b0);
        check_idle("ena_drop");

        // Reset asserted while LED 2 is being written aborts the frame.
        mode        = vb.mode;
        hue_step    = vb.step;
        hue_spread  = vb.spread;
        frame_delay = vb.delay;
        enable      = 1'b1;
        begin
            int c;
            c = 0;
            while (!(ram_wrclock === 1'b1 && ram_wraddress === 2'd2) && c < 200) begin tick(); c++; end
            check("rst_led2_write_seen", 32'(ram_wrclock), 32'd1);
        end
        RST_N = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (3) tick();
        check("mid_rst_no_req", 32'(update_request), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        clear_writes();
        RST_N = 1'b1;
        run_frame(200, vb, vb, 1'b0);
        check_idle("post_rst");

        check("wrclock_one_cycle", 32'(wide_err), 32'd0);
        check("addr_data_stable", 32'(stab_err), 32'd0);
        check("hue_in_range", 32'(hue_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the single-colour LED frame processor.
- Each frame, computes a hue for every LED and drives it on Hue to the external hue-to-RGB converter. It latches the returned COLOR and writes it into the LED frame RAM.
- Then hands the frame to the serial LED driver via a level handshake, waits a programmable inter-frame delay, and advances the base hue.
- Adds solid, rainbow, chase and blank modes, programmable hue step/spread and frame delay, and a corrected address width.

Parameters:
- LED_NUM, 16, number of LEDs per frame (>=2).
- ADDR_BIT, $clog2(LED_NUM), RAM address width.
- COLOR_W, 24, RGB word width.
- COLOR_LAT, 2, cycles from Hue change to valid COLOR (converter latency, >=1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- enable  in  1  run frames while high.
- mode  in  2  0 solid, 1 rainbow, 2 chase, 3 blank.
- hue_step  in  9  base-hue advance per frame; values >=360 treated as 359.
- hue_spread  in  9  per-LED hue offset in rainbow mode; values >=360 treated as 359.
- frame_delay  in  32  idle cycles between frames.
- Hue  out  10  hue to converter, 0..359.
- COLOR  in  COLOR_W  converter result.
- ram_wrclock  out  1  RAM write strobe.
- ram_wraddress  out  ADDR_BIT  RAM address.
- ram_data  out  COLOR_W  RAM write data.
- update_request  out  1  frame-ready request to driver.
- update_done  in  1  driver idle level (1 = idle/finished).
- busy  out  1  high in any state except IDLE.
- frame_cnt  out  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset values: Hue=0, ram_wrclock=0, ram_wraddress=0, ram_data=0, update_request=0, busy=0, frame_cnt=0. Internal state: base_hue=0, chase_pos=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately; no partial request is issued.
- IDLE: wait for enable=1 AND update_done=1.
  - On that cycle, capture mode, hue_step, hue_spread and frame_delay into registers. Inputs changing mid-frame have no effect.
  - Set led_hue=base_hue and ram_wraddress=0, then go to SETHUE.
- SETHUE: Hue<=led_hue; go to WAIT_COLOR.
- WAIT_COLOR: count COLOR_LAT cycles; go to LATCH.
- LATCH: set ram_data by mode:
  - solid and rainbow: COLOR.
  - chase: COLOR if ram_wraddress==chase_pos, else 0.
  - blank: 0.
  - Then go to WR_HI.
- WR_HI: ram_wrclock=1 for exactly one cycle. Address and data are stable from LATCH through WR_LO.
- WR_LO: ram_wrclock=0.
  - If ram_wraddress==LED_NUM-1, go to REQ.
  - Else increment ram_wraddress. In rainbow mode only, set led_hue=(led_hue+spread) mod 360, computed as a single add then one conditional subtract of 360. Go to SETHUE.
- Per-LED cost is COLOR_LAT+4 cycles. With COLOR_LAT=2 that is 6 cycles per LED.
- REQ: update_request=1. Hold it until update_done is sampled 0 (driver accepted), then drop update_request next cycle and go to WAIT_DONE.
- WAIT_DONE: wait for update_done=1, then go to DELAY and clear the delay counter.
- DELAY: count frame_delay cycles (0 = leave on the first cycle). On exit:
  - frame_cnt+1.
  - Except in blank mode, base_hue=(base_hue+step) mod 360.
  - In chase mode, chase_pos+1, wrapping LED_NUM-1 -> 0.
  - Go to IDLE.
- enable falling mid-frame: the frame completes through DELAY, then the block stays in IDLE.
- Hue wrap: 359+1 -> 0, 350+20 -> 10. All mod-360 arithmetic is done at 10 bits with a single subtract.
- Unused mode encodings: none; all four are defined.

Test Plan:
- Solid: LED_NUM=4, COLOR_LAT=2, step=1, delay=0, converter model COLOR={14'b0,Hue}.
  - 4 writes, all data=0, addresses 0..3, each wrclock one cycle wide.
  - Request issued once per frame; next frame data=1.
- Rainbow: spread=100, base=300.
  - LED hues 300, 40, 140, 240.
  - Written data matches; Hue never exceeds 359.
- Chase: 5 frames, LED_NUM=4.
  - Nonzero data only at address 0,1,2,3,0 in successive frames.
  - frame_cnt=5.
- Handshake: driver holds update_done=1 for 7 cycles after request, then 0 for 20, then 1.
  - update_request stays high until done falls.
  - DELAY starts only after done rises.
  - No RAM writes during WAIT_DONE.
- Delay and step clamp: frame_delay=50, step=400.
  - Exactly 50 cycles between WAIT_DONE exit and IDLE.
  - base_hue advances by 359.
- Reset/enable: RST_N low during LED 2 write.
  - All outputs at reset values.
  - Restart with enable=1 begins at address 0.
  - enable dropped mid-frame: frame finishes, busy falls after DELAY.
